// File: rtl/uart_host_loader_pkg.sv
// Shared opcodes, reply tags, command field positions and state encodings for the uart64 host loader.
package cray_host_pkg;

   localparam logic [3:0] OP_WRITE = 4'h1;
   localparam logic [3:0] OP_READ  = 4'h2;
   localparam logic [3:0] OP_RUN   = 4'h3;
   localparam logic [3:0] OP_HALT  = 4'h4;

   localparam logic [3:0] ACK_TAG  = 4'hA;
   localparam logic [3:0] NACK_TAG = 4'hE;

   localparam int OP_MSB  = 63;
   localparam int OP_LSB  = 60;
   localparam int CNT_MSB = 59;

   typedef enum logic [3:0] {
      IDLE, DECODE, WR_DATA, WR_PUT, WR_SUM,
      RD_REQ, RD_WAIT, RD_CAP, RD_NEXT, RD_SUM,
      ACK, NACK, TX_SEND, TX_WAIT
   } state_t;

   typedef enum logic [1:0] {HS_IDLE, HS_SEND, HS_BLANK, HS_WAIT} hs_state_t;

endpackage

// File: rtl/uart_tx_handshake.sv
// Transmit handshake toward uart64: waits for idle, pulses tx_start, blanks busy for one cycle,
// then pulses done once busy falls.
module uart_tx_handshake
   import cray_host_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic go,
   input  logic busy,
   output logic tx_start,
   output logic done
);

   hs_state_t st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= HS_IDLE;
         tx_start <= 1'b0;
         done     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         case (st)
            HS_IDLE:  if (go) st <= HS_SEND;
            HS_SEND:  if (!busy) begin
                         tx_start <= 1'b1;
                         st       <= HS_BLANK;
                      end
            // uart64 raises busy one cycle after it samples the start pulse
            HS_BLANK: st <= HS_WAIT;
            HS_WAIT:  if (!busy) begin
                         done <= 1'b1;
                         st   <= HS_IDLE;
                      end
            default:  st <= HS_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_host_loader.sv
// Host command engine behind uart64: WRITE/READ bursts, RUN/HALT of the CPU hold, ACK/NACK replies.
// Defining UART_LOADER_CHECKSUM_EN adds an XOR checksum word to WRITE and READ bursts.
module uart_host_loader
   import cray_host_pkg::*;
#(
   parameter int ADDR_W = 22,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       rx_data,
   input  logic              rx_data_rdy,
   output logic              rd_clr,
   output logic [63:0]       tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wr_data,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   input  logic [63:0]       mem_rd_data,
   output logic              cpu_hold,
   output logic              err
);

   state_t            state, ret;
   logic [63:0]       cmd;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  cnt;
   logic              blank;
   logic              hs_go, hs_done;
   logic [3:0]        op;
   logic [CNT_W-1:0]  cmd_cnt;
   logic [63:0]       ack_w;
   logic              rx_ok;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [63:0]       xsum;
`endif

   assign op      = cmd[OP_MSB:OP_LSB];
   assign cmd_cnt = cmd[CNT_MSB -: CNT_W];
   // uart64 needs two cycles after rd_clr before data_avail reflects the clear
   assign rx_ok   = rx_data_rdy && !rd_clr && !blank;

   always_comb begin
      ack_w                 = '0;
      ack_w[63:60]          = ACK_TAG;
      ack_w[59:56]          = op;
      ack_w[55 -: CNT_W]    = cmd_cnt;
      ack_w[ADDR_W-1:0]     = cmd[ADDR_W-1:0];
   end

   uart_tx_handshake u_hs (
      .clk      (clk),
      .rst      (rst),
      .go       (hs_go),
      .busy     (tx_busy),
      .tx_start (tx_start),
      .done     (hs_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ret         <= IDLE;
         cmd         <= '0;
         addr        <= '0;
         cnt         <= '0;
         blank       <= 1'b0;
         hs_go       <= 1'b0;
         rd_clr      <= 1'b0;
         tx_data     <= '0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         cpu_hold    <= 1'b1;
         err         <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         xsum        <= '0;
`endif
      end else begin
         rd_clr    <= 1'b0;
         mem_wr_en <= 1'b0;
         mem_rd_en <= 1'b0;
         hs_go     <= 1'b0;
         blank     <= rd_clr;
         case (state)
            IDLE: if (rx_ok) begin
               cmd    <= rx_data;
               rd_clr <= 1'b1;
               state  <= DECODE;
            end
            DECODE: begin
               addr <= cmd[ADDR_W-1:0];
               cnt  <= cmd_cnt;
`ifdef UART_LOADER_CHECKSUM_EN
               xsum <= '0;
`endif
               case (op)
                  OP_WRITE: state <= (cmd_cnt != '0) ? WR_DATA : ACK;
                  OP_READ:  state <= (cmd_cnt != '0) ? RD_REQ : ACK;
                  OP_RUN:   begin cpu_hold <= 1'b0; state <= ACK; end
                  OP_HALT:  begin cpu_hold <= 1'b1; state <= ACK; end
                  default:  begin err <= 1'b1; state <= NACK; end
               endcase
            end
            WR_DATA: if (rx_ok) begin
               mem_wr_data <= rx_data;
               rd_clr      <= 1'b1;
               state       <= WR_PUT;
            end
            WR_PUT: begin
               mem_wr_en <= 1'b1;
               mem_addr  <= addr;
               addr      <= addr + 1'b1;
               cnt       <= cnt - 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
               xsum      <= xsum ^ mem_wr_data;
               state     <= (cnt == CNT_W'(1)) ? WR_SUM : WR_DATA;
`else
               state     <= (cnt == CNT_W'(1)) ? ACK : WR_DATA;
`endif
            end
`ifdef UART_LOADER_CHECKSUM_EN
            // Data already in memory stays there even when the checksum disagrees
            WR_SUM: if (rx_ok) begin
               rd_clr <= 1'b1;
               if (rx_data != xsum) begin
                  err   <= 1'b1;
                  state <= NACK;
               end else begin
                  state <= ACK;
               end
            end
`endif
            RD_REQ: begin
               mem_rd_en <= 1'b1;
               mem_addr  <= addr;
               state     <= RD_WAIT;
            end
            RD_WAIT: state <= RD_CAP;
            RD_CAP: begin
               tx_data <= mem_rd_data;
`ifdef UART_LOADER_CHECKSUM_EN
               xsum    <= xsum ^ mem_rd_data;
`endif
               hs_go   <= 1'b1;
               ret     <= RD_NEXT;
               state   <= TX_SEND;
            end
            RD_NEXT: begin
               addr <= addr + 1'b1;
               cnt  <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                  state <= RD_SUM;
`else
                  state <= ACK;
`endif
               end else begin
                  state <= RD_REQ;
               end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            RD_SUM: begin
               tx_data <= xsum;
               hs_go   <= 1'b1;
               ret     <= ACK;
               state   <= TX_SEND;
            end
`endif
            ACK: begin
               tx_data <= ack_w;
               hs_go   <= 1'b1;
               ret     <= IDLE;
               state   <= TX_SEND;
            end
            NACK: begin
               tx_data <= {NACK_TAG, cmd[59:0]};
               hs_go   <= 1'b1;
               ret     <= IDLE;
               state   <= TX_SEND;
            end
            TX_SEND: if (tx_start) state <= TX_WAIT;
            TX_WAIT: if (hs_done) state <= ret;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_loader.sv
// Directed bench for uart_host_loader with uart64 rx/tx and memory models.
module tb_uart_host_loader;

   logic        clk, rst;
   logic [63:0] rx_data;
   logic        rx_data_rdy, rd_clr;
   logic [63:0] tx_data;
   logic        tx_start, tx_busy;
   logic [21:0] mem_addr;
   logic [63:0] mem_wr_data, mem_rd_data;
   logic        mem_wr_en, mem_rd_en, cpu_hold, err;

   logic        busy_int, ext_busy;
   int          bcnt, viol, rdclr_cnt, strobe_cnt;
   logic [63:0] last_tx;
   logic [63:0] rxq[$];
   logic [63:0] txq[$];
   logic [21:0] waddr[$];
   logic [63:0] wdata[$];
   logic [63:0] mem [logic [21:0]];
   int          passes, total;

   assign tx_busy = busy_int | ext_busy;

   uart_host_loader #(.ADDR_W(22), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_data_rdy (rx_data_rdy),
      .rd_clr      (rd_clr),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_en   (mem_wr_en),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_data (mem_rd_data),
      .cpu_hold    (cpu_hold),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // uart64 receive/transmit and memory models, all stepping on the falling edge
   initial begin
      rx_data = '0; rx_data_rdy = 1'b0; mem_rd_data = '0;
      busy_int = 1'b0; bcnt = 0; viol = 0; rdclr_cnt = 0; strobe_cnt = 0; last_tx = '0;
      forever begin
         @(negedge clk);
         if (rd_clr || mem_wr_en || mem_rd_en || tx_start) strobe_cnt++;
         if (rd_clr) rdclr_cnt++;
         if (rx_data_rdy && rd_clr) rx_data_rdy = 1'b0;
         else if (!rx_data_rdy && rxq.size() > 0) begin
            rx_data = rxq.pop_front();
            rx_data_rdy = 1'b1;
         end
         if (busy_int && tx_data !== last_tx) viol++;
         if (tx_start) begin
            if (tx_busy) viol++;
            txq.push_back(tx_data);
            last_tx = tx_data;
            busy_int = 1'b1;
            bcnt = 4;
         end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) busy_int = 1'b0;
         end
         if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_data;
            waddr.push_back(mem_addr);
            wdata.push_back(mem_wr_data);
         end
         if (mem_rd_en) mem_rd_data = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] mkcmd(input logic [3:0] op, input logic [15:0] n, input logic [21:0] a);
      return {op, n, 22'h0, a};
   endfunction

   task automatic wait_tx(input int n);
      int i;
      i = 0;
      while (txq.size() < n && i < 3000) begin
         @(negedge clk);
         i++;
      end
      chk("tx_word_count", 64'(txq.size()), 64'(n));
   endtask

   int tb, wb, rb, sb;

   initial begin
      passes = 0; total = 0;
      rst = 1'b1; ext_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_hold", 64'(cpu_hold), 64'h1);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_tx_data", tx_data, 64'h0);
      chk("rst_strobes", 64'({rd_clr, mem_wr_en, mem_rd_en, tx_start}), 64'h0);
      rst = 1'b0;
      sb = strobe_cnt;
      repeat (10) @(negedge clk);
      chk("idle_no_strobes", 64'(strobe_cnt - sb), 64'h0);
      chk("idle_cpu_hold", 64'(cpu_hold), 64'h1);

      // WRITE 3 words at 0x100
      tb = txq.size(); wb = waddr.size(); rb = rdclr_cnt;
      rxq.push_back(mkcmd(4'h1, 16'd3, 22'h000100));
      rxq.push_back(64'd1); rxq.push_back(64'd2); rxq.push_back(64'd3);
`ifdef UART_LOADER_CHECKSUM_EN
      rxq.push_back(64'd0);
`endif
      wait_tx(tb + 1);
      chk("wr_ack", txq[tb], 64'hA100_0300_0000_0100);
      chk("wr_count", 64'(waddr.size() - wb), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk("wr_addr", 64'(waddr[wb+i]), 64'h100 + 64'(i));
         chk("wr_data", wdata[wb+i], 64'(i + 1));
      end
`ifdef UART_LOADER_CHECKSUM_EN
      chk("wr_rd_clr", 64'(rdclr_cnt - rb), 64'd5);
`else
      chk("wr_rd_clr", 64'(rdclr_cnt - rb), 64'd4);
`endif
      chk("wr_err", 64'(err), 64'h0);

      // WRITE wrapping past the top of the address space
      tb = txq.size(); wb = waddr.size();
      rxq.push_back(mkcmd(4'h1, 16'd2, 22'h3FFFFF));
      rxq.push_back(64'hAA); rxq.push_back(64'hBB);
`ifdef UART_LOADER_CHECKSUM_EN
      rxq.push_back(64'h11);
`endif
      wait_tx(tb + 1);
      chk("wrap_ack", txq[tb], 64'hA100_0200_003F_FFFF);
      chk("wrap_addr0", 64'(waddr[wb]), 64'h3FFFFF);
      chk("wrap_addr1", 64'(waddr[wb+1]), 64'h0);
      chk("wrap_data1", wdata[wb+1], 64'hBB);

      // Preload 0x10/0x11, then READ them back while tx is initially held busy
      tb = txq.size();
      rxq.push_back(mkcmd(4'h1, 16'd2, 22'h10));
      rxq.push_back(64'hDEAD); rxq.push_back(64'hBEEF);
`ifdef UART_LOADER_CHECKSUM_EN
      rxq.push_back(64'h6042);
`endif
      wait_tx(tb + 1);
      tb = txq.size();
      ext_busy = 1'b1;
      rxq.push_back(mkcmd(4'h2, 16'd2, 22'h10));
      repeat (40) @(negedge clk);
      chk("rd_held_by_busy", 64'(txq.size() - tb), 64'h0);
      ext_busy = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      wait_tx(tb + 4);
      chk("rd_sum", txq[tb+2], 64'h6042);
      chk("rd_ack", txq[tb+3], 64'hA200_0200_0000_0010);
`else
      wait_tx(tb + 3);
      chk("rd_ack", txq[tb+2], 64'hA200_0200_0000_0010);
`endif
      chk("rd_word0", txq[tb], 64'hDEAD);
      chk("rd_word1", txq[tb+1], 64'hBEEF);

      // RUN, bad opcode, HALT, zero-length WRITE
      tb = txq.size();
      rxq.push_back(mkcmd(4'h3, 16'd0, 22'h0));
      wait_tx(tb + 1);
      chk("run_ack", txq[tb], 64'hA300_0000_0000_0000);
      chk("run_cpu_hold", 64'(cpu_hold), 64'h0);
      chk("run_err", 64'(err), 64'h0);

      tb = txq.size();
      rxq.push_back(64'h7700_0000_0000_0055);
      wait_tx(tb + 1);
      chk("bad_nack", txq[tb], 64'hE700_0000_0000_0055);
      chk("bad_err", 64'(err), 64'h1);
      chk("bad_cpu_hold", 64'(cpu_hold), 64'h0);

      tb = txq.size();
      rxq.push_back(mkcmd(4'h4, 16'd0, 22'h0));
      wait_tx(tb + 1);
      chk("halt_ack", txq[tb], 64'hA400_0000_0000_0000);
      chk("halt_cpu_hold", 64'(cpu_hold), 64'h1);

      tb = txq.size(); wb = waddr.size();
      rxq.push_back(mkcmd(4'h1, 16'd0, 22'h5));
      wait_tx(tb + 1);
      chk("wr0_ack", txq[tb], 64'hA100_0000_0000_0005);
      chk("wr0_no_writes", 64'(waddr.size() - wb), 64'h0);

`ifdef UART_LOADER_CHECKSUM_EN
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("ck_rst_err", 64'(err), 64'h0);
      tb = txq.size(); wb = waddr.size();
      rxq.push_back(mkcmd(4'h1, 16'd2, 22'h20));
      rxq.push_back(64'd5); rxq.push_back(64'd3); rxq.push_back(64'd6);
      wait_tx(tb + 1);
      chk("ck_good_ack", txq[tb], 64'hA100_0200_0000_0020);
      chk("ck_good_err", 64'(err), 64'h0);
      rxq.push_back(mkcmd(4'h1, 16'd2, 22'h20));
      rxq.push_back(64'd5); rxq.push_back(64'd3); rxq.push_back(64'd7);
      wait_tx(tb + 2);
      chk("ck_bad_nack", txq[tb+1], 64'hE000_2000_0000_0020);
      chk("ck_bad_err", 64'(err), 64'h1);
      chk("ck_bad_written", 64'(waddr.size() - wb), 64'd4);
`endif

      chk("tx_protocol_violations", 64'(viol), 64'h0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/uart_host_loader.md
Name: uart_host_loader

Overview:
- Host-side command engine directly downstream of uart64 in cray_sys_top. Consumes 64-bit words that uart64 has received and turns them into memory writes, memory reads and CPU release.
- Read data and acknowledge words are returned through uart64's transmit side.
- Holds the CPU in reset (cpu_hold) until the host issues RUN, so programs can be loaded over serial.

Parameters:
- ADDR_W, 22, memory word-address width.
- CNT_W, 16, burst word-count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  64  word from uart64 data_out.
- rx_data_rdy  in  1  uart64 data_avail; level, stays high until cleared.
- rd_clr  out  1  one-cycle pulse to uart64 enable_read; consumes the word.
- tx_data  out  64  word to uart64 data_in; stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle pulse to uart64 enable_write.
- tx_busy  in  1  uart64 busy_write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wr_data  out  64  write data.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rd_data  in  64  read data; valid exactly 1 cycle after mem_rd_en.
- cpu_hold  out  1  high holds the CPU in reset.
- err  out  1  sticky flag: bad opcode or checksum failure; cleared only by rst.

Behaviour:
- Reset values: rd_clr=0, tx_start=0, tx_data=0, mem_*=0, cpu_hold=1, err=0, state=IDLE.
- rst mid-transfer aborts immediately. A partially written burst stays in memory. A pending uart64 word is not cleared by this block.
- Command word fields:
  - [63:60] op: 1=WRITE, 2=READ, 3=RUN, 4=HALT.
  - [59:60-CNT_W] count N.
  - [ADDR_W-1:0] start address A.
  - All other bits ignored.
- Word consumption: every consumed word (in any state) takes a CONSUME cycle.
  - In that cycle: latch rx_data, pulse rd_clr, and ignore rx_data_rdy for that cycle and the next (uart64 clear latency).
- IDLE: wait for rx_data_rdy, consume the word as the command, decode into:
  - WRITE, N>0 -> WR_DATA.
  - WRITE, N=0 -> ACK.
  - READ, N>0 -> RD_REQ.
  - READ, N=0 -> ACK.
  - RUN -> cpu_hold<=0, then ACK.
  - HALT -> cpu_hold<=1, then ACK.
  - Other op -> err<=1, then NACK.
- WR_DATA: each data word is consumed, then mem_wr_en pulses 1 cycle later with mem_addr=A, mem_wr_data=word.
  - Then A<=A+1 (wraps mod 2^ADDR_W) and N<=N-1.
  - When N reaches 0 -> ACK.
- RD_REQ: pulse mem_rd_en with mem_addr=A.
- RD_CAP: capture mem_rd_data into tx_data. Go to TX_SEND with return state RD_NEXT.
- RD_NEXT: A<=A+1 (wrap) and N<=N-1. If N reaches 0 -> ACK, else -> RD_REQ.
- ACK: tx_data = {4'hA, op, count, A_start}, -> TX_SEND, return to IDLE.
- NACK: tx_data = {4'hE, 60'h0 with rx command[59:0]}, -> TX_SEND, return to IDLE.
- TX_SEND: wait until tx_busy=0, pulse tx_start.
- TX_WAIT: ignore tx_busy for 1 cycle after tx_start, then wait for tx_busy=0, then go to the return state.
- Latency, command word to first mem_wr_en: 2 cycles after the data word's rdy is seen.
- READ streams exactly N words followed by 1 ACK word.
- Words arriving while the block is transmitting stay in uart64 until the block returns to a consuming state. No loss, no overrun handling here.
- Simultaneous rx_data_rdy and tx activity: transmit completes first; receive is serviced only in IDLE or WR_DATA.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - WRITE with N>0 expects one extra word after the data: the XOR of all N data words.
  - The checksum word is consumed but not written.
  - Match -> ACK.
  - Mismatch -> err<=1 and NACK. Data words are already written and are not rolled back.
  - READ sends an extra XOR word before the ACK.
- Undefined: no checksum words in either direction; no XOR register is synthesised.

Decomposition:
- Package cray_host_pkg holds:
  - opcode localparams (OP_WRITE=4'h1, OP_READ=4'h2, OP_RUN=4'h3, OP_HALT=4'h4);
  - ACK_TAG=4'hA, NACK_TAG=4'hE;
  - field bit positions;
  - the state enumeration.
- One sub-module, uart_tx_handshake: encapsulates TX_SEND/TX_WAIT (start pulse, busy blank cycle, done pulse). It is reused by future debug-trace blocks.

Test Plan:
- Reset: cpu_hold=1, err=0, no strobes for 10 cycles after rst falls with rx_data_rdy=0.
- WRITE A=22'h000100, N=3, data 1,2,3 -> mem_wr_en at addresses 100,101,102 with data 1,2,3; then ACK word 64'hA1_0003_..._000100 transmitted. Exactly three rd_clr pulses for data plus one for the command.
- WRITE A=22'h3FFFFF, N=2 -> writes at 3FFFFF then 000000 (wrap).
- READ A=0x10, N=2 with preloaded 0xDEAD, 0xBEEF -> tx sequence 0xDEAD, 0xBEEF, ACK. tx_start never pulses while tx_busy=1.
- RUN -> cpu_hold falls and ACK is sent. Opcode 0x7 -> err=1, NACK 64'hE7..., cpu_hold unchanged.
- With UART_LOADER_CHECKSUM_EN: WRITE N=2 data 5,3 with checksum 6 -> ACK. Same burst with checksum 7 -> both words written, err=1, NACK.
